// File: rtl/biss_c_pkg.sv
// biss_c_pkg: shared states, CRC6 constants and width helper for the BiSS-C slave
package biss_c_pkg;
   typedef enum logic [3:0] {IDLE, ACK, START, CDS, DATA, ERR, WARN, CRC, TIMEOUT} state_t;
   localparam int CRC_WIDTH = 6;
   localparam logic [CRC_WIDTH-1:0] CRC_POLY = 6'h03;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/biss_c_crc6.sv
// biss_c_crc6: serial MSB-first CRC6 (x^6+x+1, init 0), one bit per enable
module biss_c_crc6
   import biss_c_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 en,
   input  logic                 bit_in,
   output logic [CRC_WIDTH-1:0] crc
);
   logic fb;
   assign fb = crc[CRC_WIDTH-1] ^ bit_in;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) crc <= '0;
      else if (clear) crc <= '0;
      else if (en) crc <= {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
endmodule

// File: rtl/biss_c_slave_tx.sv
// biss_c_slave_tx: BiSS-C slave transmitter driving SLO from oversampled MA edges
module biss_c_slave_tx
   import biss_c_pkg::*;
#(
   parameter int DATA_WIDTH   = 26,
   parameter int ACK_BITS     = 2,
   parameter int TIMEOUT_CLKS = 200,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ma_in,
   output logic                  slo_out,
   input  logic [DATA_WIDTH-1:0] pos_data,
   input  logic                  err_n,
   input  logic                  warn_n,
   output logic                  frame_busy,
   output logic                  data_latched,
   output logic                  frame_done,
   output logic                  frame_abort
);
   localparam int FW = DATA_WIDTH + 2;
   localparam int CW = clog2((DATA_WIDTH > 16 ? DATA_WIDTH : 16) + 1);
   localparam int TW = clog2(TIMEOUT_CLKS + 1);
   logic [SYNC_STAGES-1:0] ma_sync;
   logic ma_s, ma_prev, rise, fall;
   logic [TW-1:0] to_cnt;
   logic to_hit;
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [FW-1:0] sh, sh_nx;
   logic slo_nx, busy_nx, latch_nx, done_nx, abort_nx, crc_clr, crc_en;
   logic [CRC_WIDTH-1:0] crc_val;
   logic [2:0] ci;
   logic last_ack, last_data, last_crc;
   assign ma_s = ma_sync[SYNC_STAGES-1];
   assign to_hit = to_cnt == TW'(TIMEOUT_CLKS);
   assign ci = 3'(CRC_WIDTH - 1) - cnt[2:0];
   assign last_ack = cnt == CW'(ACK_BITS - 1);
   assign last_data = cnt == CW'(DATA_WIDTH - 1);
   assign last_crc = cnt == CW'(CRC_WIDTH);
   // strobes are registered, so SLO moves SYNC_STAGES+1 clocks after MA is first sampled
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ma_sync <= '1;
         ma_prev <= 1'b1;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         ma_sync <= {ma_sync[SYNC_STAGES-2:0], ma_in};
         ma_prev <= ma_s;
         rise <= ma_s & ~ma_prev;
         fall <= ~ma_s & ma_prev;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) to_cnt <= '0;
      else if (state == IDLE || !ma_s) to_cnt <= '0;
      else if (!to_hit) to_cnt <= to_cnt + 1'b1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         sh <= '0;
         slo_out <= 1'b1;
         frame_busy <= 1'b0;
         data_latched <= 1'b0;
         frame_done <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         sh <= sh_nx;
         slo_out <= slo_nx;
         frame_busy <= busy_nx;
         data_latched <= latch_nx;
         frame_done <= done_nx;
         frame_abort <= abort_nx;
      end
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      sh_nx = sh;
      slo_nx = slo_out;
      busy_nx = frame_busy;
      latch_nx = 1'b0;
      done_nx = 1'b0;
      abort_nx = 1'b0;
      crc_clr = 1'b0;
      crc_en = 1'b0;
      if (state == IDLE) begin
         if (fall) begin
            sh_nx = {pos_data, err_n, warn_n};
            cnt_nx = '0;
            busy_nx = 1'b1;
            latch_nx = 1'b1;
            crc_clr = 1'b1;
            state_nx = ACK;
         end
      end else if (to_hit) begin
         slo_nx = 1'b1;
         busy_nx = 1'b0;
         done_nx = state == TIMEOUT;
         abort_nx = state != TIMEOUT;
         state_nx = IDLE;
      end else if (rise) begin
         case (state)
            ACK: begin
               slo_nx = 1'b0;
               cnt_nx = last_ack ? '0 : cnt + 1'b1;
               state_nx = last_ack ? START : ACK;
            end
            START: begin
               slo_nx = 1'b1;
               state_nx = CDS;
            end
            CDS: begin
               slo_nx = 1'b0;
               state_nx = DATA;
            end
            // data, nE and nW leave the same shift register and all feed the CRC
            DATA, ERR, WARN: begin
               slo_nx = sh[FW-1];
               sh_nx = {sh[FW-2:0], 1'b0};
               crc_en = 1'b1;
               cnt_nx = (state == DATA && !last_data) ? cnt + 1'b1 : '0;
               state_nx = state == DATA ? (last_data ? ERR : DATA) : state == ERR ? WARN : CRC;
            end
            CRC: begin
               slo_nx = last_crc ? 1'b0 : ~crc_val[ci];
               cnt_nx = cnt + 1'b1;
               state_nx = last_crc ? TIMEOUT : CRC;
            end
            default: ;
         endcase
      end
   end
   biss_c_crc6 u_crc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (crc_clr),
      .en     (crc_en),
      .bit_in (sh[FW-1]),
      .crc    (crc_val)
   );
endmodule

// File: tb/tb_biss_c_slave_tx.sv
// tb_biss_c_slave_tx: directed frames against a queue of expected SLO bits
module tb_biss_c_slave_tx;
   localparam int ACK_BITS = 2;
   localparam int FRAME_RISES = ACK_BITS + 2 + 26 + 2 + 6 + 1;
   logic clk, rst_n, ma_in, slo_out, err_n, warn_n;
   logic frame_busy, data_latched, frame_done, frame_abort;
   logic [25:0] pos_data, lat_val;
   logic exp_q[$];
   logic exp_slo;
   bit jitter;
   int checks, errors, rise_no;
   int n_lat, n_done, n_abort;
   biss_c_slave_tx dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ma_in        (ma_in),
      .slo_out      (slo_out),
      .pos_data     (pos_data),
      .err_n        (err_n),
      .warn_n       (warn_n),
      .frame_busy   (frame_busy),
      .data_latched (data_latched),
      .frame_done   (frame_done),
      .frame_abort  (frame_abort)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      lat_val <= pos_data;
      if (data_latched) n_lat <= n_lat + 1;
      if (frame_done) n_done <= n_done + 1;
      if (frame_abort) n_abort <= n_abort + 1;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic push_frame(input logic [25:0] p, input logic e, input logic w);
      logic [5:0] c;
      logic [27:0] f;
      c = 6'h00;
      f = {p, e, w};
      repeat (ACK_BITS) exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      for (int i = 27; i >= 0; i--) begin
         exp_q.push_back(f[i]);
         c = {c[4:0], 1'b0} ^ ((c[5] ^ f[i]) ? 6'h03 : 6'h00);
      end
      for (int i = 5; i >= 0; i--) exp_q.push_back(~c[i]);
      exp_q.push_back(1'b0);
   endtask
   task automatic ma_low();
      @(negedge clk) ma_in = 1'b0;
      repeat (9) @(negedge clk);
   endtask
   task automatic ma_rise();
      logic nb;
      rise_no++;
      @(negedge clk) ma_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) chk($sformatf("slo_hold[%0d]", rise_no), 32'(slo_out), 32'(exp_slo));
      nb = (exp_q.size() > 0) ? exp_q.pop_front() : exp_slo;
      @(negedge clk) chk($sformatf("slo_bit[%0d]", rise_no), 32'(slo_out), 32'(nb));
      exp_slo = nb;
      repeat (7) @(negedge clk);
   endtask
   task automatic run_frame(input logic [25:0] p, input logic e, input logic w,
                            input int nrises, input bit jit, input int rst_rise);
      int k, lat0, done0, abort0;
      bit full;
      full = nrises == FRAME_RISES;
      pos_data = p;
      err_n = e;
      warn_n = w;
      jitter = jit;
      rise_no = 0;
      if (jit) fork
         while (jitter) begin
            @(negedge clk);
            pos_data = 26'($urandom);
         end
      join_none
      @(negedge clk);
      lat0 = n_lat;
      done0 = n_done;
      abort0 = n_abort;
      ma_in = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!data_latched && k < 9);
      chk("latch_seen", 32'(data_latched), 32'd1);
      chk("busy_on", 32'(frame_busy), 32'd1);
      push_frame(jit ? lat_val : p, e, w);
      repeat (10 - k) @(negedge clk);
      for (int i = 0; i < nrises; i++) begin
         if (i > 0) ma_low();
         if (rst_rise == i + 1) begin
            @(negedge clk) ma_in = 1'b1;
            @(negedge clk);
            #2 rst_n = 1'b0;
            #1 chk("rst_async_slo", 32'(slo_out), 32'd1);
            chk("rst_async_busy", 32'(frame_busy), 32'd0);
            exp_q.delete();
            exp_slo = 1'b1;
            jitter = 1'b0;
            repeat (5) @(negedge clk);
            rst_n = 1'b1;
            repeat (20) @(negedge clk);
            chk("rst_idle_slo", 32'(slo_out), 32'd1);
            return;
         end
         ma_rise();
      end
      jitter = 1'b0;
      k = 11;
      do begin
         @(negedge clk);
         k++;
         if (full && k == 110) chk("timeout_slo_low", 32'(slo_out), 32'd0);
      end while (!frame_done && !frame_abort && k < 500);
      chk("end_time", 32'(k >= 200 && k <= 206), 32'd1);
      chk("end_slo", 32'(slo_out), 32'd1);
      chk("end_busy", 32'(frame_busy), 32'd0);
      @(negedge clk);
      chk("latched_pulses", 32'(n_lat - lat0), 32'd1);
      chk("done_pulses", 32'(n_done - done0), full ? 32'd1 : 32'd0);
      chk("abort_pulses", 32'(n_abort - abort0), full ? 32'd0 : 32'd1);
      if (full) chk("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      exp_slo = 1'b1;
      repeat (5) @(negedge clk);
   endtask
   initial begin
      int bad;
      checks = 0;
      errors = 0;
      n_lat = 0;
      n_done = 0;
      n_abort = 0;
      exp_slo = 1'b1;
      jitter = 1'b0;
      rst_n = 1'b0;
      ma_in = 1'b1;
      pos_data = '0;
      err_n = 1'b1;
      warn_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_slo", 32'(slo_out), 32'd1);
      chk("reset_busy", 32'(frame_busy), 32'd0);
      rst_n = 1'b1;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (slo_out !== 1'b1 || frame_busy !== 1'b0 || data_latched !== 1'b0 ||
             frame_done !== 1'b0 || frame_abort !== 1'b0) bad++;
      end
      chk("idle_quiet", 32'(bad), 32'd0);
      run_frame(26'h0000000, 1'b0, 1'b0, FRAME_RISES, 1'b0, 0);
      run_frame(26'h2AAAAAA, 1'b1, 1'b0, FRAME_RISES, 1'b0, 0);
      run_frame(26'h1234567, 1'b1, 1'b1, FRAME_RISES, 1'b1, 0);
      run_frame(26'h3FFFFFF, 1'b1, 1'b1, 10, 1'b0, 0);
      run_frame(26'h155AA33, 1'b0, 1'b1, FRAME_RISES, 1'b0, 0);
      run_frame(26'h0000000, 1'b1, 1'b1, FRAME_RISES, 1'b0, 15);
      run_frame(26'h0F0F0F5, 1'b1, 1'b0, FRAME_RISES, 1'b0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
